// File: rtl/seu_ff_file_scrub_pkg.sv
// Shared types and helpers for the replicated, scrubbed flip-flop register file.
// Holds the scrub FSM state encoding and the per-bit 3-way majority function.
package seu_ff_file_scrub_pkg;

  typedef enum logic [1:0] {
    SCRUB_WAIT  = 2'd0,
    SCRUB_CHECK = 2'd1,
    SCRUB_FIX   = 2'd2
  } scrub_state_e;

  localparam int unsigned FIX_CNT_W = 16;

  // Per-bit majority; callers apply it across any data width bit by bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/seu_ff_file_scrub_vote.sv
// Combinational R-input voter: bitwise majority of the replicas plus a flag
// raised when any replica differs from the voted value. R=1 passes replica 0.
module seu_ff_file_scrub_vote
  import seu_ff_file_scrub_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned R = 3
) (
  input  logic [W-1:0] rep [R],
  output logic [W-1:0] voted,
  output logic         mismatch
);

  if (R == 3) begin : g_tmr
    always_comb begin
      voted = '0;
      for (int b = 0; b < W; b++) begin
        voted[b] = maj3(rep[0][b], rep[1][b], rep[2][b]);
      end
    end

    always_comb begin
      mismatch = 1'b0;
      for (int r = 0; r < 3; r++) begin
        mismatch = mismatch | (|(rep[r] ^ voted));
      end
    end
  end else begin : g_single
    assign voted    = rep[0];
    assign mismatch = 1'b0;
  end

endmodule

// File: rtl/seu_ff_file_scrub.sv
// Replicated register file with majority-voted reads and a background scrubber
// that rewrites the voted value whenever the replicas of an entry disagree.
module seu_ff_file_scrub
  import seu_ff_file_scrub_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter int unsigned D         = 32,
  parameter int unsigned R         = 3,
  parameter int unsigned RP        = 2,
  parameter int unsigned ADDW      = $clog2(D),
  parameter int unsigned SCRUB_INT = 16,
  parameter logic [W-1:0] RSTVAL   = '0
) (
  input  logic                 s_c_i,
  input  logic                 s_r_i,
  input  logic                 s_we_i,
  input  logic [ADDW-1:0]      s_wa_i,
  input  logic [W-1:0]         s_d_i,
  input  logic [ADDW-1:0]      s_ra_i [RP],
  output logic [W-1:0]         s_q_o [RP],
  output logic                 s_rerr_o [RP],
  output logic                 s_fix_o,
  output logic [FIX_CNT_W-1:0] s_fix_cnt_o,
  input  logic                 s_fix_clr_i,
  output logic [ADDW-1:0]      s_scrub_ptr_o,
  output scrub_state_e         s_scrub_st_o
);

  localparam int unsigned CNT_W = (SCRUB_INT > 1) ? $clog2(SCRUB_INT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SCRUB_INT - 1);
  localparam logic [ADDW-1:0]  LAST_ADDR  = ADDW'(D - 1);
  localparam logic [FIX_CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0] rep_q [D][R];

  scrub_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDW-1:0]  ptr_q, ptr_d, ptr_next;
  logic [W-1:0]     fix_val_q, fix_val_d;
  logic             fix_we;
  logic             fix_o_q;
  logic [FIX_CNT_W-1:0] fix_cnt_q;

  logic             wa_ok;
  logic [W-1:0]     scr_rep [R];
  logic [W-1:0]     scr_voted;
  logic             scr_mismatch;

  assign wa_ok = (32'(s_wa_i) < D);

  // Replica storage: a fix and a functional write may land in the same cycle;
  // the functional write is applied last so it wins on a shared address.
  always_ff @(posedge s_c_i) begin
    if (s_r_i) begin
      for (int e = 0; e < D; e++) begin
        for (int r = 0; r < R; r++) begin
          rep_q[e][r] <= RSTVAL;
        end
      end
    end else begin
      if (fix_we) begin
        for (int r = 0; r < R; r++) begin
          rep_q[ptr_q][r] <= fix_val_q;
        end
      end
      if (s_we_i && wa_ok) begin
        for (int r = 0; r < R; r++) begin
          rep_q[s_wa_i][r] <= s_d_i;
        end
      end
    end
  end

  for (genvar p = 0; p < RP; p++) begin : g_rd
    logic [W-1:0] rep_sel [R];
    logic [W-1:0] voted;
    logic         mism;
    logic         ra_ok;

    assign ra_ok = (32'(s_ra_i[p]) < D);

    always_comb begin
      for (int r = 0; r < R; r++) begin
        rep_sel[r] = ra_ok ? rep_q[s_ra_i[p]][r] : '0;
      end
    end

    seu_ff_file_scrub_vote #(.W(W), .R(R)) u_vote (
      .rep      (rep_sel),
      .voted    (voted),
      .mismatch (mism)
    );

    assign s_q_o[p]    = ra_ok ? voted : '0;
    assign s_rerr_o[p] = ra_ok & mism;
  end

  always_comb begin
    for (int r = 0; r < R; r++) begin
      scr_rep[r] = rep_q[ptr_q][r];
    end
  end

  seu_ff_file_scrub_vote #(.W(W), .R(R)) u_scrub_vote (
    .rep      (scr_rep),
    .voted    (scr_voted),
    .mismatch (scr_mismatch)
  );

  assign ptr_next = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge s_c_i) begin
    if (s_r_i) begin
      state_q   <= SCRUB_WAIT;
      cnt_q     <= CNT_RELOAD;
      ptr_q     <= '0;
      fix_val_q <= '0;
      fix_o_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      fix_val_q <= fix_val_d;
      fix_o_q   <= fix_we;
    end
  end

  // A functional write to the entry being fixed aborts the fix; the scrubber
  // still moves on because the written value is fresh and consistent.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    fix_val_d = fix_val_q;
    fix_we    = 1'b0;
    case (state_q)
      SCRUB_WAIT: begin
        if (R == 3) begin
          if (cnt_q == '0) begin
            state_d = SCRUB_CHECK;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      SCRUB_CHECK: begin
        if (scr_mismatch) begin
          fix_val_d = scr_voted;
          state_d   = SCRUB_FIX;
        end else begin
          ptr_d   = ptr_next;
          cnt_d   = CNT_RELOAD;
          state_d = SCRUB_WAIT;
        end
      end
      SCRUB_FIX: begin
        fix_we  = !(s_we_i && (s_wa_i == ptr_q));
        ptr_d   = ptr_next;
        cnt_d   = CNT_RELOAD;
        state_d = SCRUB_WAIT;
      end
      default: begin
        state_d = SCRUB_WAIT;
      end
    endcase
  end

  // Clear beats a same-cycle increment.
  always_ff @(posedge s_c_i) begin
    if (s_r_i) begin
      fix_cnt_q <= '0;
    end else if (s_fix_clr_i) begin
      fix_cnt_q <= '0;
    end else if (fix_we && (fix_cnt_q != CNT_MAX)) begin
      fix_cnt_q <= fix_cnt_q + 1'b1;
    end
  end

  assign s_fix_o       = fix_o_q;
  assign s_fix_cnt_o   = fix_cnt_q;
  assign s_scrub_ptr_o = ptr_q;
  assign s_scrub_st_o  = state_q;

endmodule

// File: tb/tb_seu_ff_file_scrub.sv
// Bench for seu_ff_file_scrub: directed scrub scenarios plus random traffic,
// all checked against a timestamp-based replica model kept in the bench.
module tb_seu_ff_file_scrub;
  import seu_ff_file_scrub_pkg::*;

  localparam int W    = 32;
  localparam int D    = 6;
  localparam int R    = 3;
  localparam int RP   = 2;
  localparam int ADDW = 3;
  localparam int SI   = 3;
  localparam logic [W-1:0] RSTV = 32'hA5A5_0000;
  localparam int DB   = 4;
  localparam int SIB  = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            we = 1'b0;
  logic            clr = 1'b0;
  logic [ADDW-1:0] wa = '0;
  logic [W-1:0]    d = '0;
  logic [ADDW-1:0] ra [RP];
  logic [W-1:0]    q [RP];
  logic            rerr [RP];
  logic            fix_o;
  logic [15:0]     fix_cnt;
  logic [ADDW-1:0] ptr;
  scrub_state_e    st;

  logic [1:0]      ra_b [1];
  logic [7:0]      q_b [1];
  logic            rerr_b [1];
  logic            fix_o_b;
  logic [15:0]     fix_cnt_b;
  logic [1:0]      ptr_b;
  scrub_state_e    st_b;
  logic            we_b = 1'b0;
  logic            clr_b = 1'b0;
  logic [1:0]      wa_b = '0;
  logic [7:0]      d_b = '0;

  seu_ff_file_scrub #(
    .W(W), .D(D), .R(R), .RP(RP), .ADDW(ADDW), .SCRUB_INT(SI), .RSTVAL(RSTV)
  ) dut (
    .s_c_i(clk), .s_r_i(rst), .s_we_i(we), .s_wa_i(wa), .s_d_i(d),
    .s_ra_i(ra), .s_q_o(q), .s_rerr_o(rerr), .s_fix_o(fix_o),
    .s_fix_cnt_o(fix_cnt), .s_fix_clr_i(clr), .s_scrub_ptr_o(ptr),
    .s_scrub_st_o(st)
  );

  seu_ff_file_scrub #(
    .W(8), .D(DB), .R(3), .RP(1), .ADDW(2), .SCRUB_INT(SIB), .RSTVAL(8'h00)
  ) dut_b (
    .s_c_i(clk), .s_r_i(rst), .s_we_i(we_b), .s_wa_i(wa_b), .s_d_i(d_b),
    .s_ra_i(ra_b), .s_q_o(q_b), .s_rerr_o(rerr_b), .s_fix_o(fix_o_b),
    .s_fix_cnt_o(fix_cnt_b), .s_fix_clr_i(clr_b), .s_scrub_ptr_o(ptr_b),
    .s_scrub_st_o(st_b)
  );

  // reference model: replica contents plus scrub timing as absolute cycle numbers
  logic [W-1:0] m_mem [D][R];
  int           m_ptr, m_n, m_next;
  logic         m_pend;
  logic [W-1:0] m_fix_val;
  logic [15:0]  m_cnt;
  logic         m_fix_o;

  // scoreboard for the small instance's pointer walk
  logic [1:0] exp_q [$];
  int         ptrb_moves, ptrb_last_n;
  logic [1:0] ptrb_last;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void m_vote(input int e, output logic [W-1:0] v, output logic err);
    v = '0;
    err = 1'b0;
    for (int b = 0; b < W; b++) begin
      int ones = 0;
      for (int r = 0; r < R; r++) ones += int'(m_mem[e][r][b]);
      v[b] = (ones * 2 > R);
    end
    for (int r = 0; r < R; r++) if (m_mem[e][r] != v) err = 1'b1;
  endfunction

  task automatic model_update();
    logic [W-1:0] v;
    logic         e;
    logic         fix_now;
    if (rst) begin
      for (int i = 0; i < D; i++) for (int r = 0; r < R; r++) m_mem[i][r] = RSTV;
      m_ptr = 0; m_cnt = '0; m_fix_o = 1'b0; m_n = 0; m_next = SI; m_pend = 1'b0;
      return;
    end
    fix_now = 1'b0;
    if (m_pend) begin
      m_pend = 1'b0;
      if (!(we && int'(wa) == m_ptr)) begin
        for (int r = 0; r < R; r++) m_mem[m_ptr][r] = m_fix_val;
        fix_now = 1'b1;
      end
      m_ptr  = (m_ptr + 1) % D;
      m_next = m_n + SI + 1;
    end else if (m_n == m_next) begin
      m_vote(m_ptr, v, e);
      if (e) begin
        m_pend = 1'b1;
        m_fix_val = v;
      end else begin
        m_ptr  = (m_ptr + 1) % D;
        m_next = m_n + SI + 1;
      end
    end
    if (clr) m_cnt = '0;
    else if (fix_now && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
    m_fix_o = fix_now;
    if (we && int'(wa) < D) for (int r = 0; r < R; r++) m_mem[wa][r] = d;
    m_n++;
  endtask

  task automatic check_outputs();
    logic [W-1:0] v;
    logic         e;
    logic [1:0]   nx;
    for (int p = 0; p < RP; p++) begin
      if (int'(ra[p]) < D) m_vote(int'(ra[p]), v, e);
      else begin v = '0; e = 1'b0; end
      check_val($sformatf("q%0d", p), q[p], v);
      check_val($sformatf("rerr%0d", p), 32'(rerr[p]), 32'(e));
    end
    check_val("fix_o", 32'(fix_o), 32'(m_fix_o));
    check_val("fix_cnt", 32'(fix_cnt), 32'(m_cnt));
    check_val("ptr", 32'(ptr), 32'(m_ptr));
    if (ptr_b != ptrb_last) begin
      nx = exp_q.pop_front();
      check_val("ptrb_seq", 32'(ptr_b), 32'(nx));
      exp_q.push_back(nx + 2'd1);
      if (ptrb_moves > 0) check_val("ptrb_gap", 32'(m_n - ptrb_last_n), 32'(SIB + 1));
      ptrb_last_n = m_n;
      ptrb_last   = ptr_b;
      ptrb_moves++;
    end
  endtask

  task automatic tick(input bit do_chk);
    #1;
    if (do_chk) check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // static so the indices may appear in a nonblocking hierarchical write
  task inject(input int e, input int r, input int b);
    m_mem[e][r][b] = ~m_mem[e][r][b];
    dut.rep_q[e][r] <= m_mem[e][r];
  endtask

  task automatic wait_fix_cycle(input string tag, input int e);
    bit found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_pend && (e < 0 || m_ptr == e)) begin
        found = 1'b1;
        break;
      end
      tick(1'b1);
    end
    if (!found) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [15:0] cnt_before;
    ra[0] = 3'd5;
    ra[1] = 3'd0;
    ra_b[0] = 2'd0;
    exp_q.push_back(2'd1);
    ptrb_moves = 0; ptrb_last = 2'd0; ptrb_last_n = 0;
    @(negedge clk);

    // reset, with a write that must be overridden
    rst = 1'b1; we = 1'b1; wa = 3'd5; d = 32'h1234_5678;
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0; we = 1'b0;
    #1;
    check_val("rst_q", q[0], RSTV);
    check_val("rst_rerr", 32'(rerr[0]), 32'd0);
    check_val("rst_cnt", 32'(fix_cnt), 32'd0);
    check_val("rst_ptr", 32'(ptr), 32'd0);
    check_val("rst_ptr_b", 32'(ptr_b), 32'd0);
    tick(1'b1);

    // write entry 5; same-cycle read shows the old value
    we = 1'b1; wa = 3'd5; d = 32'hDEAD_BEEF;
    #1 check_val("wr_same_cycle", q[0], RSTV);
    tick(1'b1);
    we = 1'b0;
    #1 check_val("wr_next_cycle", q[0], 32'hDEAD_BEEF);
    tick(1'b1);

    // upset at entry 3, replica 1, bit 7; scrubber must repair it once
    inject(3, 1, 7);
    ra[1] = 3'd3;
    #1;
    check_val("e3_read", q[1], RSTV);
    check_val("e3_rerr_set", 32'(rerr[1]), 32'd1);
    wait_fix_cycle("e3_fix", 3);
    tick(1'b1);
    check_val("e3_fix_pulse", 32'(fix_o), 32'd1);
    check_val("e3_fix_cnt", 32'(fix_cnt), 32'd1);
    tick(1'b1);
    #1;
    check_val("e3_pulse_once", 32'(fix_o), 32'd0);
    check_val("e3_rerr_clear", 32'(rerr[1]), 32'd0);

    // functional write to the entry being fixed aborts the fix
    inject(2, 0, 0);
    cnt_before = m_cnt;
    wait_fix_cycle("e2_fix", 2);
    we = 1'b1; wa = 3'd2; d = 32'h1357_9BDF; ra[0] = 3'd2;
    tick(1'b1);
    we = 1'b0;
    #1;
    check_val("abort_no_pulse", 32'(fix_o), 32'd0);
    check_val("abort_cnt", 32'(fix_cnt), 32'(cnt_before));
    check_val("abort_ptr", 32'(ptr), 32'd3);
    check_val("abort_data", q[0], 32'h1357_9BDF);
    check_val("abort_rerr", 32'(rerr[0]), 32'd0);
    tick(1'b1);

    // saturation at 0xFFFF
    dut.fix_cnt_q <= 16'hFFFF;
    m_cnt = 16'hFFFF;
    inject((m_ptr + 2) % D, 2, 31);
    wait_fix_cycle("sat_fix", -1);
    tick(1'b1);
    check_val("sat_pulse", 32'(fix_o), 32'd1);
    check_val("sat_cnt", 32'(fix_cnt), 32'h0000_FFFF);

    // clear wins over a same-cycle increment
    inject((m_ptr + 1) % D, 0, 12);
    wait_fix_cycle("clr_fix", -1);
    clr = 1'b1;
    tick(1'b1);
    clr = 1'b0;
    check_val("clr_pulse", 32'(fix_o), 32'd1);
    check_val("clr_cnt", 32'(fix_cnt), 32'd0);

    // random traffic with occasional upsets and clears
    for (int i = 0; i < 400; i++) begin
      we  = ($urandom_range(0, 9) < 3);
      wa  = ADDW'($urandom_range(0, 7));
      d   = $urandom;
      clr = ($urandom_range(0, 49) == 0);
      ra[0] = ADDW'($urandom_range(0, 7));
      ra[1] = ADDW'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0)
        inject($urandom_range(0, D - 1), $urandom_range(0, R - 1), $urandom_range(0, W - 1));
      tick(1'b1);
    end
    we = 1'b0;
    clr = 1'b0;

    check_val("ptrb_moves", 32'(ptrb_moves), 32'((m_n - 1) / 2));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
